// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux between four valid/ready requesters.
// Optional transfer counter with clear, enabled by defining MUX4_ARB_STATS_EN.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  input  logic             out_ready,
`ifdef MUX4_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      xfer_count,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       ack,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg;
  logic [3:0] gnt_reg;
  logic [1:0] sel_reg;
  logic [1:0] ptr_reg;
  logic [3:0] burst_cnt_reg;

  logic [3:0] rot_req;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;
  logic       req_g;
  logic       xfer;
  logic       release_now;

  // rot_req[k] is the request of requester ptr+k, so the lowest set bit is the winner
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    pick_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) pick_off = 2'(k);
    end
  end

  assign pick_idx    = ptr_reg + pick_off;
  assign req_g       = req[sel_reg];
  assign out_valid   = (state_reg == GRANT) && req_g;
  assign xfer        = out_valid && out_ready;
  assign ack         = xfer ? gnt_reg : 4'b0000;
  assign release_now = (state_reg == GRANT) &&
                       ((xfer && (burst_cnt_reg == 4'(BURST_MAX - 1))) || !req_g);

  always_comb begin
    case (sel_reg)
      2'b00:   out_data = data_a;
      2'b01:   out_data = data_b;
      2'b10:   out_data = data_c;
      default: out_data = data_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= 4'b0000;
      sel_reg       <= 2'b00;
      ptr_reg       <= 2'b00;
      burst_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req != 4'b0000) begin
            state_reg     <= GRANT;
            gnt_reg       <= 4'b0001 << pick_idx;
            sel_reg       <= pick_idx;
            burst_cnt_reg <= 4'd0;
          end else begin
            gnt_reg <= 4'b0000;
          end
        end
        default: begin
          if (release_now) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            ptr_reg   <= sel_reg + 2'd1;
          end else if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
          end
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign s0   = sel_reg[1];
  assign s1   = sel_reg[0];
  assign busy = (state_reg == GRANT);

`ifdef MUX4_ARB_STATS_EN
  logic [15:0] xfer_count_reg;

  // clear has priority over a same-cycle transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_reg <= 16'd0;
    end else if (stats_clr) begin
      xfer_count_reg <= 16'd0;
    end else if (xfer) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule
